fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
- Sits directly downstream of the team's register-based synchronous FIFO and drains it in bounded bursts onto a valid/ready stream with a last marker.
- A burst starts when the FIFO is no longer almost-empty, or when a lone residue has waited TIMEOUT cycles.
- The FIFO read strobe comes from a flop, so the FIFO's look-ahead Empty flag never forms a combinational loop.

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- BURST_LEN, 4, maximum words per burst; must be >= 1 and <= the FIFO's AE_LEVEL.
- TIMEOUT, 64, consecutive IDLE cycles with a non-empty FIFO before a flush burst; >= 1.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  reset; asynchronous, active-high.
- i_Fifo_AE  in  1  FIFO almost-empty (FIFO count < AE_LEVEL).
- i_Fifo_Empty  in  1  FIFO empty (look-ahead: also high when count==1 and read strobe high).
- i_Fifo_Data  in  WIDTH  FIFO head word; valid whenever the FIFO is non-empty.
- o_Fifo_Rd_En  out  1  FIFO read strobe, registered.
- o_Tx_DV  out  1  output word valid.
- o_Tx_Data  out  WIDTH  output word.
- o_Tx_Last  out  1  final word of the current burst.
- i_Tx_Ready  in  1  downstream accepts the word when o_Tx_DV & i_Tx_Ready at a clock edge.
- o_Busy  out  1  high when state != IDLE.

Behaviour:
- Reset: i_Rst high clears state (IDLE), counters, buffer occupancy and all outputs to 0 immediately, with no clock edge. Buffer data contents are don't-care.
- Output buffer: 2-entry skid FIFO of {data, last}, occupancy occ 0..2.
  - Head drives o_Tx_Data/o_Tx_Last; o_Tx_DV = (occ != 0).
  - Pop on DV & Ready. Push at any edge where o_Fifo_Rd_En is high, capturing i_Fifo_Data.
  - Simultaneous push and pop leave occ unchanged.
- Read issue: o_Fifo_Rd_En next = (state==BURST) & (rd_cnt < BURST_LEN) & !last_issued & !i_Fifo_Empty & (occ_next <= 1).
  - occ_next is the occupancy after this edge's push/pop.
  - This yields one word per cycle with Ready held high and never overflows the buffer.
- Last tagging: a pushed word is last if rd_cnt == BURST_LEN-1, or if i_Fifo_Empty is high during its read cycle (look-ahead). Either condition sets last_issued.
- rd_cnt counts pushes in the current burst; cleared on entry to BURST.
- States:
  - IDLE: go to BURST if !i_Fifo_AE. Otherwise go to BURST if tmo_cnt == TIMEOUT-1 and !i_Fifo_Empty.
  - tmo_cnt increments each IDLE cycle with !i_Fifo_Empty, clears when the FIFO is empty or the state is not IDLE, and saturates.
  - BURST: go to DRAIN on the edge that pushes the last-tagged word.
  - DRAIN: no reads. Go to IDLE on the edge where the last-tagged word is popped.
  - From IDLE, re-trigger is allowed the cycle after returning. Bursts never overlap.
- Latency:
  - Trigger edge -> Rd_En high next cycle.
  - Rd_En edge -> word on o_Tx_Data in the following cycle.
  - First word therefore appears 2 cycles after the trigger edge.
- Boundaries:
  - A write into the FIFO coincident with its look-ahead Empty still ends the burst. Remaining words go in a later burst; nothing is lost or duplicated.
  - Ready held low stalls indefinitely. o_Tx_Data/o_Tx_Last stay stable while DV & !Ready.
  - o_Tx_Last is high only on exactly one word per burst.
  - Async reset mid-burst discards buffered words. The FIFO pointer advance for words already read is not undone.

Test Plan:
- Reset, write A0..A3 into the FIFO (AE_LEVEL=4), Ready=1 -> Rd_En high exactly 4 consecutive cycles; outputs A0..A3 on consecutive cycles; Last only on A3; o_Busy falls one cycle after A3 is accepted.
- Same 4 words, Ready pattern 1,0,0,1,0,1,1... -> exact order A0..A3 with no loss or duplication; data held stable while stalled; occ never exceeds 2; Rd_En never high when occ_next == 2.
- Write 2 words B0,B1, no further writes -> nothing emitted for 63 cycles; flush burst starts on timeout; B0, B1 emitted with Last on B1.
- Write 9 words back-to-back -> two bursts of 4 (Last on 4th and 8th words), then the 9th word alone after the TIMEOUT wait, with Last set.
- Assert i_Rst asynchronously between clock edges after 2 words of a burst are accepted -> DV, Last, Rd_En and Busy drop to 0 before the next edge; after release with the FIFO empty, Rd_En stays 0.
- FIFO empty for 200 cycles after reset -> Rd_En, DV and Busy stay 0 throughout; tmo_cnt never advances.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side signals and the outgoing valid/ready stream of fifo_burst_reader.
// The reader drives the read strobe and the stream through the master modport.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 8
);
    logic             i_Fifo_AE;
    logic             i_Fifo_Empty;
    logic [WIDTH-1:0] i_Fifo_Data;
    logic             o_Fifo_Rd_En;
    logic             o_Tx_DV;
    logic [WIDTH-1:0] o_Tx_Data;
    logic             o_Tx_Last;
    logic             i_Tx_Ready;
    logic             o_Busy;

    modport master (
        input  i_Fifo_AE,
        input  i_Fifo_Empty,
        input  i_Fifo_Data,
        input  i_Tx_Ready,
        output o_Fifo_Rd_En,
        output o_Tx_DV,
        output o_Tx_Data,
        output o_Tx_Last,
        output o_Busy
    );

    modport slave (
        output i_Fifo_AE,
        output i_Fifo_Empty,
        output i_Fifo_Data,
        output i_Tx_Ready,
        input  o_Fifo_Rd_En,
        input  o_Tx_DV,
        input  o_Tx_Data,
        input  o_Tx_Last,
        input  o_Busy
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a look-ahead-Empty synchronous FIFO in bounded bursts onto a valid/ready
// stream with a last marker, through a 2-entry skid buffer and a registered read strobe.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    fifo_burst_reader_if.master  bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rdCnt_q, rdCnt_d;
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
    logic             lastIssued_q, lastIssued_d;
    logic             rdEn_q, rdEn_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             last0_q, last0_d, last1_q, last1_d;

    logic push;
    logic pop;
    logic pushLast;

    // A word read while Empty is already high was the FIFO's final word.
    assign push     = rdEn_q;
    assign pop      = (occ_q != 2'd0) && bus.i_Tx_Ready;
    assign pushLast = (rdCnt_q == LAST_IDX) || bus.i_Fifo_Empty;

    // Skid buffer: entry 0 is the head; a pop shifts entry 1 forward.
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    data0_d = bus.i_Fifo_Data;
                    last0_d = pushLast;
                end else begin
                    data1_d = bus.i_Fifo_Data;
                    last1_d = pushLast;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = bus.i_Fifo_Data;
                    last0_d = pushLast;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = bus.i_Fifo_Data;
                    last1_d = pushLast;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rdCnt_d      = rdCnt_q;
        lastIssued_d = lastIssued_q;
        tmoCnt_d     = '0;
        case (state_q)
            IDLE: begin
                if (!bus.i_Fifo_Empty) begin
                    tmoCnt_d = (tmoCnt_q == TMO_MAX) ? tmoCnt_q : tmoCnt_q + 1'b1;
                end
                if (!bus.i_Fifo_AE || ((tmoCnt_q == TMO_MAX) && !bus.i_Fifo_Empty)) begin
                    state_d      = BURST;
                    rdCnt_d      = '0;
                    lastIssued_d = 1'b0;
                end
            end
            BURST: begin
                if (push) begin
                    rdCnt_d = rdCnt_q + 1'b1;
                    if (pushLast) begin
                        lastIssued_d = 1'b1;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last0_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Next-cycle values keep the strobe one word per cycle without overfilling the buffer.
        rdEn_d = (state_d == BURST) && (rdCnt_d < BURST_MAX) && !lastIssued_d
                 && !bus.i_Fifo_Empty && (occ_d <= 2'd1);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            rdCnt_q      <= '0;
            tmoCnt_q     <= '0;
            lastIssued_q <= 1'b0;
            rdEn_q       <= 1'b0;
            occ_q        <= 2'd0;
            data0_q      <= '0;
            data1_q      <= '0;
            last0_q      <= 1'b0;
            last1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdCnt_q      <= rdCnt_d;
            tmoCnt_q     <= tmoCnt_d;
            lastIssued_q <= lastIssued_d;
            rdEn_q       <= rdEn_d;
            occ_q        <= occ_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            last0_q      <= last0_d;
            last1_q      <= last1_d;
        end
    end

    assign bus.o_Fifo_Rd_En = rdEn_q;
    assign bus.o_Tx_DV      = (occ_q != 2'd0);
    assign bus.o_Tx_Data    = data0_q;
    assign bus.o_Tx_Last    = last0_q && (occ_q != 2'd0);
    assign bus.o_Busy       = (state_q != IDLE);
endmodule
